// File: rtl/pulse_meas_ns.sv
// pulse_meas_ns: measures the high time of sig_in in units of DIV clock cycles.
// Optional feature macro: PULSE_MEAS_SYNC_EN adds a two-flop input synchronizer
// (gated by en, cleared by reset) ahead of edge detection. Without it, sig_in
// is used directly and must already be synchronous to clk.
module pulse_meas_ns #(
    parameter int unsigned N   = 8,
    parameter int unsigned DIV = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic         abort,
    input  logic         sig_in,
    output logic [N-1:0] width,
    output logic         done,
    output logic         busy,
    output logic         ovf
);

    // Prescaler only needs to reach DIV-1; keep at least one bit for DIV=1.
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);
    localparam logic [N-1:0] UnitsMax = '1;

    typedef enum logic [1:0] {StIdle, StArmed, StMeas, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [N-1:0]  units_q, units_d;
    logic [N-1:0]  width_q, width_d;
    logic          ovf_q, ovf_d;
    logic          s_prev_q;
    logic          s;
    logic          rise, fall;

`ifdef PULSE_MEAS_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer; frozen with the rest of the block when en=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else if (en) begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = sig_in;
`endif

    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;

    // Previous-sample register for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_prev_q <= 1'b0;
        end else if (en) begin
            s_prev_q <= s;
        end
    end

    // State and measurement registers; reset wins over en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            presc_q <= '0;
            units_q <= '0;
            width_q <= '0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            presc_q <= presc_d;
            units_q <= units_d;
            width_q <= width_d;
            ovf_q   <= ovf_d;
        end
    end

    logic          count_en;
    logic          count_clear;
    logic [PW-1:0] presc_base;
    logic [N-1:0]  units_base;

    // Next-state logic and the saturating unit counter.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        units_d     = units_q;
        width_d     = width_q;
        ovf_d       = ovf_q;
        count_en    = 1'b0;
        count_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A rise coinciding with start is deliberately not captured.
                if (start) begin
                    state_d = StArmed;
                    presc_d = '0;
                    units_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            StArmed: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (rise) begin
                    // The edge cycle is the first high cycle: count it from zero.
                    state_d     = StMeas;
                    count_en    = 1'b1;
                    count_clear = 1'b1;
                end
            end
            StMeas: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (fall) begin
                    state_d = StDone;
                    width_d = units_q;
                end else if (s) begin
                    count_en = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        presc_base = count_clear ? '0 : presc_q;
        units_base = count_clear ? '0 : units_q;

        if (count_en) begin
            units_d = units_base;
            if (presc_base == PrescLast) begin
                presc_d = '0;
                if (units_base == UnitsMax) begin
                    ovf_d = 1'b1;
                end else begin
                    units_d = units_base + 1'b1;
                end
            end else begin
                presc_d = presc_base + 1'b1;
            end
        end
    end

    assign width = width_q;
    assign ovf   = ovf_q;
    assign done  = (state_q == StDone);
    assign busy  = (state_q == StArmed) || (state_q == StMeas);

endmodule

// File: tb/tb_pulse_meas_ns.sv
// Self-checking bench for pulse_meas_ns: table of pulse lengths run against an
// N=8 and an N=4 instance sharing stimulus, plus hand-written corner sequences.
module tb_pulse_meas_ns;

`ifdef PULSE_MEAS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sig_in = 1'b0;
    logic [7:0] width;
    logic       done, busy, ovf;
    logic [3:0] width4;
    logic       done4, busy4, ovf4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_meas_ns #(.N(8), .DIV(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .start  (start),
        .abort  (abort),
        .sig_in (sig_in),
        .width  (width),
        .done   (done),
        .busy   (busy),
        .ovf    (ovf)
    );

    pulse_meas_ns #(.N(4), .DIV(10)) dut4 (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .start  (start),
        .abort  (abort),
        .sig_in (sig_in),
        .width  (width4),
        .done   (done4),
        .busy   (busy4),
        .ovf    (ovf4)
    );

    typedef struct {
        int high;
        int w8;
        int o8;
        int w4;
        int o4;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Steps until done rises (bounded); checks the edge count after the fall.
    task automatic wait_done(input string name);
        int lat;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({name, " latency"}, lat, LAT);
    endtask

    // Steps n cycles and reports whether done was seen high at any of them.
    task automatic watch_no_done(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (done) seen = 1;
        end
    endtask

    initial begin
        int seen;

        vecs[0] = '{high: 100, w8: 10, o8: 0, w4: 10, o4: 0};
        vecs[1] = '{high: 99,  w8: 9,  o8: 0, w4: 9,  o4: 0};
        vecs[2] = '{high: 200, w8: 20, o8: 0, w4: 15, o4: 1};
        vecs[3] = '{high: 150, w8: 15, o8: 0, w4: 15, o4: 0};
        vecs[4] = '{high: 9,   w8: 0,  o8: 0, w4: 0,  o4: 0};
        vecs[5] = '{high: 1,   w8: 0,  o8: 0, w4: 0,  o4: 0};
        vecs[6] = '{high: 10,  w8: 1,  o8: 0, w4: 1,  o4: 0};
        vecs[7] = '{high: 160, w8: 16, o8: 0, w4: 15, o4: 1};

        // Reset state
        step();
        step();
        reset = 1'b0;
        chk("reset width", width, 0);
        chk("reset done", done, 0);
        chk("reset busy", busy, 0);
        chk("reset ovf", ovf, 0);

        // Table-driven pulses
        for (int i = 0; i < 8; i++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk($sformatf("row%0d busy armed", i), busy, 1);
            chk($sformatf("row%0d ovf cleared", i), ovf, 0);
            chk($sformatf("row%0d ovf4 cleared", i), ovf4, 0);
            sig_in = 1'b1;
            repeat (vecs[i].high) step();
            sig_in = 1'b0;
            wait_done($sformatf("row%0d", i));
            chk($sformatf("row%0d done4", i), done4, 1);
            chk($sformatf("row%0d busy at done", i), busy, 0);
            chk($sformatf("row%0d width", i), width, vecs[i].w8);
            chk($sformatf("row%0d ovf", i), ovf, vecs[i].o8);
            chk($sformatf("row%0d width4", i), width4, vecs[i].w4);
            chk($sformatf("row%0d ovf4", i), ovf4, vecs[i].o4);
            step();
            chk($sformatf("row%0d done one cycle", i), done, 0);
        end

        // Abort mid-pulse: no done, width kept
        start = 1'b1;
        step();
        start = 1'b0;
        sig_in = 1'b1;
        repeat (50) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        sig_in = 1'b0;
        watch_no_done(8, seen);
        chk("abort no done", seen, 0);
        chk("abort width kept", width, 16);
        chk("abort width4 kept", width4, 15);

        // Abort coincident with the fall wins
        start = 1'b1;
        step();
        start = 1'b0;
        sig_in = 1'b1;
        repeat (20) step();
        sig_in = 1'b0;
        repeat (LAT - 1) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort vs fall busy", busy, 0);
        chk("abort vs fall done", done, 0);
        watch_no_done(6, seen);
        chk("abort vs fall no done", seen, 0);
        chk("abort vs fall width", width, 16);

        // en=0 gap mid-pulse, done held while frozen
        start = 1'b1;
        step();
        start = 1'b0;
        sig_in = 1'b1;
        repeat (50) step();
        en = 1'b0;
        repeat (20) step();
        en = 1'b1;
        repeat (50) step();
        sig_in = 1'b0;
        wait_done("en gap");
        chk("en gap width", width, 10);
        en = 1'b0;
        repeat (5) step();
        chk("en gap done held", done, 1);
        chk("en gap busy", busy, 0);
        en = 1'b1;
        step();
        chk("en gap done released", done, 0);

        // sig_in already high when armed: wait for low then a fresh rise
        sig_in = 1'b1;
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        sig_in = 1'b0;
        repeat (5) step();
        chk("prehigh still armed", busy, 1);
        chk("prehigh no done", done, 0);
        sig_in = 1'b1;
        repeat (40) step();
        sig_in = 1'b0;
        wait_done("prehigh");
        chk("prehigh width", width, 4);
        step();

        // start and rise in the same IDLE cycle: the rise is not captured
        sig_in = 1'b1;
        repeat (LAT - 1) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        sig_in = 1'b0;
        watch_no_done(LAT + 4, seen);
        chk("same-cycle rise no done", seen, 0);
        chk("same-cycle rise armed", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("same-cycle abort", busy, 0);

        // Reset mid-pulse, with en low to show reset ignores en
        start = 1'b1;
        step();
        start = 1'b0;
        sig_in = 1'b1;
        repeat (30) step();
        reset = 1'b1;
        en = 1'b0;
        step();
        chk("midreset width", width, 0);
        chk("midreset width4", width4, 0);
        chk("midreset done", done, 0);
        chk("midreset busy", busy, 0);
        chk("midreset ovf4", ovf4, 0);
        reset = 1'b0;
        en = 1'b1;
        sig_in = 1'b0;
        watch_no_done(8, seen);
        chk("midreset no done", seen, 0);
        chk("midreset idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_meas_ns.md
PULSE_MEAS_NS -- requirements
Module: pulse_meas_ns

Interface
REQ-001 Parameter N, default 8: width in bits of the measured-result output and of the unit counter.
REQ-002 Parameter DIV, default 10: clock cycles per result unit (10 -> 100 ns units at 100 MHz).
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 Port en  input  1  clock enable; 0 freezes every register, including the synchronizer.
REQ-006 Port start  input  1  arm request; accepted only in IDLE.
REQ-007 Port abort  input  1  cancel the measurement in progress; return to IDLE without done.
REQ-008 Port sig_in  input  1  asynchronous pulse to be measured (high time).
REQ-009 Port width  output  N  last completed measurement, in DIV-cycle units, truncated.
REQ-010 Port done  output  1  high while state==DONE.
REQ-011 Port busy  output  1  high in ARMED or MEAS.
REQ-012 Port ovf  output  1  sticky saturation flag for the current or last measurement.

Function
REQ-013 Conditioned signal s SHALL be the synchronizer output when SYNC is enabled, or sig_in directly when it is not; register s_prev SHALL hold the previous enabled-cycle value of s.
REQ-014 Edge definitions: rise = s & ~s_prev; fall = ~s & s_prev.
REQ-015 The FSM SHALL have states IDLE, ARMED, MEAS and DONE, and SHALL advance only on cycles with en=1.
REQ-016 IDLE: start=1 -> ARMED; this transition clears the unit counter, the prescaler and ovf; width is held.
REQ-017 ARMED: rise -> MEAS with prescaler=1 and units=0; the edge cycle counts as the first high cycle.
REQ-018 MEAS with s=1: if prescaler==DIV-1, set prescaler=0 and units+1; otherwise prescaler+1.
REQ-019 Units SHALL saturate at 2^N-1; an increment attempted at saturation SHALL set ovf=1 and hold units.
REQ-020 MEAS with fall: -> DONE and width<=units. Result = floor(H/DIV) (saturated), where H = number of enabled edges at which s was sampled high.
REQ-021 DONE -> IDLE after exactly one enabled cycle; done SHALL stay asserted while en=0 holds the FSM in DONE.
REQ-022 abort=1 in ARMED or MEAS -> IDLE on the next edge; no done pulse, width unchanged. abort has priority over fall.
REQ-023 start SHALL be ignored outside IDLE; abort SHALL be ignored in IDLE and DONE.
REQ-024 start and a rise in the same IDLE cycle: only arming occurs; the rise is not captured.
REQ-025 If s is already high when the block is armed, no measurement starts until s goes low and then rises again.
REQ-026 Latency from the fall of sig_in to done: 3 enabled edges with SYNC, 1 without.

Reset
REQ-027 When reset=1 at a rising edge, the block SHALL enter IDLE with width=0, done=0, busy=0, ovf=0, units=0, prescaler=0, s_prev=0 and all synchronizer flops=0, regardless of en.
REQ-028 Reset mid-measurement SHALL abandon the measurement with no done pulse.

Configuration
REQ-029 Macro PULSE_MEAS_SYNC_EN defined: sig_in passes through a two-flop synchronizer, reset to 0 and gated by en, before edge detection.
REQ-030 Macro PULSE_MEAS_SYNC_EN undefined: no synchronizer; s=sig_in, and sig_in must be synchronous to clk. All other behaviour is identical apart from latency (REQ-026).

Verification (N=8, DIV=10, PULSE_MEAS_SYNC_EN defined, en=1 unless stated)
REQ-031 start; sig_in high for 100 cycles -> done high for 1 cycle, 3 edges after sig_in falls; width=10; ovf=0; busy falls with done.
REQ-032 start; sig_in high for 99 cycles -> width=9 (truncation).
REQ-033 Build with N=4; start; sig_in high for 200 cycles -> width=15, ovf=1; next start clears ovf.
REQ-034 start; sig_in high; abort after 50 high cycles -> no done, busy=0 next cycle, width keeps previous value.
REQ-035 start; 120-cycle pulse with en=0 for 20 cycles mid-pulse -> width=10; done held high while en=0 in DONE.
REQ-036 sig_in high before start, held 30 cycles, then low 5 cycles, then high 40 cycles -> width=4; reset mid-pulse -> all outputs 0, no done.
